// File: rtl/scroll_window_gen_if.sv
// Bundle between the message/scroll control source and the scroll window generator.
// The master drives the message and control inputs; the slave returns the visible window and status.
interface scroll_window_gen_if;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [4:0] wr_data;
  logic [4:0] msg_len;
  logic       start;
  logic       stop;
  logic       pause;
  logic       dir;
  logic [4:0] win3;
  logic [4:0] win2;
  logic [4:0] win1;
  logic [4:0] win0;
  logic [3:0] pos;
  logic       busy;
  logic       wrap;

  modport master (
    output wr_en, wr_addr, wr_data, msg_len, start, stop, pause, dir,
    input  win3, win2, win1, win0, pos, busy, wrap
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, msg_len, start, stop, pause, dir,
    output win3, win2, win1, win0, pos, busy, wrap
  );
endinterface

// File: rtl/scroll_window_gen.sv
// Scrolls a 4-character window through a message buffer of up to 16 codes and
// presents the visible codes, registered, to the downstream digit-mux stage.
module scroll_window_gen #(
  parameter int unsigned STEP_DIV = 100_000_000
) (
  input  logic               fastclk,
  input  logic               resetin,
  scroll_window_gen_if.slave bus
);
  localparam int unsigned PW = $clog2(STEP_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(STEP_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_t;

  state_t        state_q, state_d;
  logic [3:0]    pos_q, pos_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [4:0]    len_q, len_d;
  logic          wrap_q, wrap_d;
  logic          busy;
  logic [4:0]    len_div;
  logic [4:0]    msg_buf_q [16];

  always_ff @(posedge fastclk or posedge resetin) begin
    if (resetin) begin
      state_q <= S_IDLE;
      pos_q   <= 4'd0;
      presc_q <= '0;
      len_q   <= 5'd0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      presc_q <= presc_d;
      len_q   <= len_d;
      wrap_q  <= wrap_d;
    end
  end

  // stop outranks start, start outranks pause; a step due in a stop cycle is dropped
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    presc_d = presc_q;
    len_d   = len_q;
    wrap_d  = 1'b0;
    if (bus.stop) begin
      state_d = S_IDLE;
      pos_d   = 4'd0;
      presc_d = '0;
    end else if (bus.start) begin
      pos_d   = 4'd0;
      presc_d = '0;
      if (bus.msg_len == 5'd0) begin
        state_d = S_IDLE;
        len_d   = 5'd0;
      end else begin
        state_d = S_RUN;
        len_d   = (bus.msg_len > 5'd16) ? 5'd16 : bus.msg_len;
      end
    end else begin
      case (state_q)
        S_RUN: begin
          if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            if (!bus.dir) begin
              if ({1'b0, pos_q} == len_q - 5'd1) begin
                pos_d  = 4'd0;
                wrap_d = 1'b1;
              end else begin
                pos_d = pos_q + 4'd1;
              end
            end else begin
              if (pos_q == 4'd0) begin
                pos_d  = 4'(len_q - 5'd1);
                wrap_d = 1'b1;
              end else begin
                pos_d = pos_q - 4'd1;
              end
            end
          end else begin
            presc_d = presc_q + 1'b1;
          end
          if (bus.pause) state_d = S_PAUSE;
        end
        S_PAUSE: begin
          if (!bus.pause) state_d = S_RUN;
        end
        default: begin
          pos_d   = 4'd0;
          presc_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    busy = (state_q != S_IDLE);
  end

  always_ff @(posedge fastclk or posedge resetin) begin
    if (resetin) begin
      for (int i = 0; i < 16; i++) msg_buf_q[i] <= 5'h1F;
    end else if (bus.wr_en) begin
      msg_buf_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Divisor forced to 1 when empty so the modulo stays defined; output is blanked anyway
  assign len_div = (len_q == 5'd0) ? 5'd1 : len_q;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_win
      logic [4:0] idx;
      logic [4:0] win_q;
      assign idx = 5'(({1'b0, pos_q} + 5'(3 - gi)) % len_div);
      always_ff @(posedge fastclk or posedge resetin) begin
        if (resetin)               win_q <= 5'h1F;
        else if (len_q == 5'd0)    win_q <= 5'h1F;
        else                       win_q <= msg_buf_q[idx[3:0]];
      end
    end
  endgenerate

  assign bus.win3 = g_win[3].win_q;
  assign bus.win2 = g_win[2].win_q;
  assign bus.win1 = g_win[1].win_q;
  assign bus.win0 = g_win[0].win_q;
  assign bus.pos  = pos_q;
  assign bus.busy = busy;
  assign bus.wrap = wrap_q;
endmodule
